// File: rtl/imm_builder.sv
// imm_builder: immediate generator with ordered output FIFO; define IMM_BUILDER_MOVK_EN for the MOVK accumulator
module imm_builder #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [25:0]              In,
  input  logic [2:0]               Ctrl,
  input  logic [1:0]               Op,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [WIDTH-1:0]         BusImm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [63:0]      res, ins, lane;
  logic [5:0]       sh;
  logic             accept, pop;
  assign in_ready  = count_q < CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign count     = count_q;
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign BusImm    = out_valid ? mem_q[rd_q] : '0;
  assign sh        = {Op, 4'b0000};
`ifdef IMM_BUILDER_MOVK_EN
  logic [63:0] acc_q, acc_d;
  // decode the format; MOVK splices the halfword into the running accumulator
  always_comb begin
    lane = 64'hFFFF << sh;
    ins  = {48'b0, In[20:5]} << sh;
    res  = Ctrl == 3'b000 ? {{52{In[21]}}, In[21:10]} :
           Ctrl == 3'b001 ? {{55{In[20]}}, In[20:12]} :
           Ctrl == 3'b011 ? {{45{In[23]}}, In[23:5]} :
           Ctrl == 3'b100 ? ins :
           Ctrl == 3'b101 ? (acc_q & ~lane) | ins :
                            {{38{In[25]}}, In};
    acc_d = accept && (Ctrl == 3'b100 || Ctrl == 3'b101) ? res : acc_q;
  end
  // accumulator keeps the full 64-bit value regardless of WIDTH
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) acc_q <= '0;
    else acc_q <= acc_d;
`else
  // decode the format; Ctrl=101 falls through to the branch format
  always_comb begin
    lane = 64'hFFFF << sh;
    ins  = {48'b0, In[20:5]} << sh;
    res  = Ctrl == 3'b000 ? {{52{In[21]}}, In[21:10]} :
           Ctrl == 3'b001 ? {{55{In[20]}}, In[20:12]} :
           Ctrl == 3'b011 ? {{45{In[23]}}, In[23:5]} :
           Ctrl == 3'b100 ? ins & lane :
                            {{38{In[25]}}, In};
  end
`endif
  // pointer and occupancy update; flush wins over accept and pop
  always_comb begin
    wr_d    = flush ? '0 : accept ? wr_q + PW'(1) : wr_q;
    rd_d    = flush ? '0 : pop ? rd_q + PW'(1) : rd_q;
    count_d = flush ? '0 : count_q + CW'(accept) - CW'(pop);
  end
  // FIFO control state
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  // storage needs no reset since BusImm is gated by occupancy
  always_ff @(posedge CLK)
    if (accept) mem_q[wr_q] <= res[WIDTH-1:0];
endmodule

// File: tb/tb_imm_builder.sv
// tb_imm_builder: random and directed checks of imm_builder against a queue-based model
module tb_imm_builder;
`ifdef IMM_BUILDER_MOVK_EN
  localparam bit MOVK = 1'b1;
`else
  localparam bit MOVK = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [25:0] in_b = '0;
  logic [2:0] ctrl = '0;
  logic [1:0] op = '0;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic rdy0, ov0, rdy1, ov1;
  logic [63:0] bus0;
  logic [31:0] bus1;
  logic [1:0] cnt0;
  logic [2:0] cnt1;
  int nvec = 0, nerr = 0;
  logic [63:0] q0[$], q1[$];
  logic [63:0] acc0 = '0, acc1 = '0;
  always #5 clk = ~clk;
  imm_builder #(.WIDTH(64), .DEPTH(2)) dut0 (
    .CLK(clk), .RESET_N(rst_n), .In(in_b), .Ctrl(ctrl), .Op(op), .in_valid(in_valid),
    .in_ready(rdy0), .flush(flush), .BusImm(bus0), .out_valid(ov0), .out_ready(out_ready), .count(cnt0));
  imm_builder #(.WIDTH(32), .DEPTH(4)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .In(in_b), .Ctrl(ctrl), .Op(op), .in_valid(in_valid),
    .in_ready(rdy1), .flush(flush), .BusImm(bus1), .out_valid(ov1), .out_ready(out_ready), .count(cnt1));
  function automatic logic [63:0] imm(input logic [25:0] i, input logic [2:0] c, input logic [1:0] o, input logic [63:0] acc);
    logic [3:0][15:0] h;
    h = '0;
    case (c)
      3'd0: return longint'($signed(i[21:10]));
      3'd1: return longint'($signed(i[20:12]));
      3'd3: return longint'($signed(i[23:5]));
      3'd4: begin h[o] = i[20:5]; return h; end
      3'd5: if (MOVK) begin h = acc; h[o] = i[20:5]; return h; end
      default: ;
    endcase
    return longint'($signed(i));
  endfunction
  function automatic logic [25:0] mk(input logic [15:0] f);
    return {5'b0, f, 5'b0};
  endfunction
  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      acc0 <= '0;
      acc1 <= '0;
    end else if (flush) begin
      q0.delete();
      q1.delete();
    end else begin
      if (in_valid && q0.size() < 2) begin
        if (out_ready && q0.size() != 0) void'(q0.pop_front());
        q0.push_back(imm(in_b, ctrl, op, acc0));
        if (ctrl == 3'd4 || (MOVK && ctrl == 3'd5)) acc0 <= imm(in_b, ctrl, op, acc0);
      end else if (out_ready && q0.size() != 0) void'(q0.pop_front());
      if (in_valid && q1.size() < 4) begin
        if (out_ready && q1.size() != 0) void'(q1.pop_front());
        q1.push_back(imm(in_b, ctrl, op, acc1));
        if (ctrl == 3'd4 || (MOVK && ctrl == 3'd5)) acc1 <= imm(in_b, ctrl, op, acc1);
      end else if (out_ready && q1.size() != 0) void'(q1.pop_front());
    end
  always @(negedge clk) begin
    check("cnt0", 64'(cnt0), 64'(q0.size()));
    check("valid0", 64'(ov0), 64'(q0.size() != 0));
    check("ready0", 64'(rdy0), 64'(q0.size() < 2));
    check("bus0", bus0, q0.size() != 0 ? q0[0] : 64'd0);
    check("cnt1", 64'(cnt1), 64'(q1.size()));
    check("valid1", 64'(ov1), 64'(q1.size() != 0));
    check("ready1", 64'(rdy1), 64'(q1.size() < 4));
    check("bus1", 64'(bus1), q1.size() != 0 ? 64'(q1[0][31:0]) : 64'd0);
  end
  task automatic step(input logic v, input logic [2:0] c, input logic [1:0] o, input logic [25:0] i, input logic r, input logic f);
    in_valid = v; ctrl = c; op = o; in_b = i; out_ready = r; flush = f;
    @(posedge clk);
    #1;
  endtask
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(ov0), 64'd0);
    check("rst_bus", bus0, 64'd0);
    check("rst_ready", 64'(rdy0), 64'd1);
    check("rst_cnt", 64'(cnt0), 64'd0);
    #3 rst_n = 1'b1;
  endtask
  initial begin
    #2;
    check("por_cnt", 64'(cnt0), 64'd0);
    check("por_ready", 64'(rdy0), 64'd1);
    check("por_valid", 64'(ov0), 64'd0);
    check("por_bus", bus0, 64'd0);
    #10 rst_n = 1'b1;
    step(0, 0, 0, 0, 1, 1);
    step(1, 3'd0, 0, 26'h0FFF << 10, 1, 0);
    check("i_fff", bus0, 64'hFFFF_FFFF_FFFF_FFFF);
    check("i_fff_valid", 64'(ov0), 64'd1);
    step(1, 3'd4, 2'd1, mk(16'h1234), 1, 0);
    check("movz", bus0, 64'h0000_0000_1234_0000);
    step(1, 3'd5, 2'd0, mk(16'hABCD), 1, 0);
    check("movk", bus0, MOVK ? 64'h0000_0000_1234_ABCD : 64'h0000_0000_0015_79A0);
    step(1, 3'd4, 2'd2, mk(16'h5555), 1, 0);
    check("movz_w32", 64'(bus1), 64'd0);
    check("movz_w32_valid", 64'(ov1), 64'd1);
    check("movz_w64", bus0, 64'h0000_5555_0000_0000);
    step(0, 0, 0, 0, 1, 1);
    step(1, 3'd0, 0, 26'd1 << 10, 0, 0);
    step(1, 3'd0, 0, 26'd2 << 10, 0, 0);
    step(1, 3'd0, 0, 26'd3 << 10, 0, 0);
    check("full_cnt", 64'(cnt0), 64'd2);
    check("full_ready", 64'(rdy0), 64'd0);
    check("full_head", bus0, 64'd1);
    step(1, 3'd0, 0, 26'd3 << 10, 1, 0);
    check("order2", bus0, 64'd2);
    check("order2_cnt", 64'(cnt0), 64'd1);
    step(1, 3'd0, 0, 26'd3 << 10, 1, 0);
    check("order3", bus0, 64'd3);
    step(0, 0, 0, 0, 1, 0);
    check("drained", 64'(ov0), 64'd0);
    check("drained_bus", bus0, 64'd0);
    step(1, 3'd0, 0, 26'd7 << 10, 0, 0);
    step(1, 3'd0, 0, 26'd7 << 10, 0, 0);
    check("pre_flush_cnt", 64'(cnt0), 64'd2);
    step(1, 3'd0, 0, 26'd7 << 10, 1, 1);
    check("flush_cnt", 64'(cnt0), 64'd0);
    check("flush_valid", 64'(ov0), 64'd0);
    step(0, 0, 0, 0, 1, 0);
    check("flush_ignored", 64'(cnt0), 64'd0);
    step(1, 3'd0, 0, 26'd9 << 10, 0, 0);
    check("pre_rst_cnt", 64'(cnt0), 64'd1);
    reset_pulse();
    step(1, 3'd5, 2'd0, mk(16'h00FF), 1, 0);
    check("movk_after_rst", bus0, MOVK ? 64'h0000_0000_0000_00FF : 64'h0000_0000_0000_1FE0);
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 7, 3'($urandom), 2'($urandom), 26'($urandom),
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 399) == 0) reset_pulse();
    end
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
